retire_stage: RTL and testbench
===============================

Name: retire_stage

Overview:
- Commit stage directly downstream of the ROB in the 3-way OoO core.
- Each cycle it examines the ROB head window and commits the oldest completed entries in order.
- Freed physical registers go back to the free list; the architectural map table is updated.
- On a committed mispredict it raises BPRecoverEN with the recovery PC; on a committed halt it stops retirement and raises halt.

Parameters:
WAYS, 3, superscalar width; index WAYS-1 is the oldest (ROB head) entry.
PR, 6, physical register tag width.
XLEN, 32, PC width.
ARCH_REGS, 32, number of architectural registers (5-bit index).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rob_head_entry  in  WAYS x ROB_ENTRY_PACKET  head window from ROB; fields used: valid, completed, Tnew, Told, arch_reg, precise_state_need, target_pc, halt
retire_valid  out  WAYS  per-way commit strobe to ROB (head advance)
free_valid  out  WAYS  per-way free-list push strobe
free_pr  out  WAYS x PR  Told tags pushed to the free list
BPRecoverEN  out  1  one-cycle flush/recover pulse to ROB, rename, fetch
recover_pc  out  XLEN  fetch redirect PC, valid while BPRecoverEN=1
archmap_out  out  ARCH_REGS x PR  architectural map; rename restores from it on BPRecoverEN
halt  out  1  sticky program-halt indication
retired_count  out  32  total committed instruction count

Behaviour:
- Reset (async, immediate):
  - state=NORMAL, BPRecoverEN=0, recover_pc=0, halt=0, retired_count=0.
  - archmap entry i = i.
  - retire_valid, free_valid and free_pr all 0 while reset is high.
- State machine, states NORMAL, RECOVER, HALTED:
  - NORMAL->RECOVER when a precise_state_need entry commits.
  - RECOVER->NORMAL after exactly one cycle.
  - NORMAL->HALTED when a halt entry commits.
  - HALTED is left only by reset.
- Commit rule in NORMAL (combinational, same cycle). Way w commits iff all of:
  - valid and completed are set;
  - every older way (w+1..WAYS-1) commits;
  - no older way has precise_state_need or halt set.
  So commits form a contiguous run from way WAYS-1 downward, and a mispredicting or halting entry is the youngest committing entry of its cycle.
- In RECOVER and HALTED: retire_valid=0 and free_valid=0 regardless of input.
- For each committing way with arch_reg!=0:
  - free_valid=1, free_pr=Told;
  - archmap[arch_reg]<=Tnew at the clock edge.
- For a committing way with arch_reg==0: retire_valid=1, free_valid=0, no map write.
- Same arch_reg written by several committing ways in one cycle: the youngest way's Tnew wins; every way's Told is freed.
- Mispredict commit:
  - Next edge: BPRecoverEN<=1 and recover_pc<=target_pc of that entry.
  - BPRecoverEN drops the following edge (exactly 1 cycle high).
  - archmap_out already includes that cycle's updates when BPRecoverEN is high.
- Halt commit: next edge halt<=1 and stays high; the halt entry itself counts as committed.
- retired_count += popcount(retire_valid) each edge; wraps modulo 2^32.
- Invalid or incomplete head (ROB empty): no commits, all outputs keep their hold/idle values.

Test Plan:
- Reset, then ways 2..0 valid+completed with (arch,Told,Tnew) = (1,1,32), (2,2,33), (3,3,34) -> retire_valid=111, free_pr = {1,2,3}; next cycle archmap[1..3] = 32,33,34 and retired_count=3.
- Way 2 completed, way 1 not completed, way 0 completed -> retire_valid=100, only Told of way 2 freed, retired_count += 1.
- Way 1 has precise_state_need=1, target_pc=32, ways 2..0 all completed -> retire_valid=110. Next cycle BPRecoverEN=1 and recover_pc=32 with retire_valid=000 despite valid input. One cycle later BPRecoverEN=0.
- Ways 2 and 1 both write arch 5 (Tnew 40 and 41), both completed -> archmap[5]=41 and both Told values freed; way 0 with arch_reg 0 -> retire_valid=1, free_valid=0.
- Way 2 has halt=1 -> retire_valid=100; halt=1 next cycle; later completed entries -> retire_valid=000 indefinitely.
- Assert reset while in RECOVER -> BPRecoverEN and halt drop immediately, archmap returns to identity, retired_count=0.

Source files
------------

// File: rtl/retire_stage.sv
// In-order commit stage behind the ROB: retires the oldest completed run of the
// head window, frees Told tags, maintains the architectural map, and raises recovery/halt.
package retire_stage_pkg;
  localparam int PR   = 6;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic            completed;
    logic [PR-1:0]   t_new;
    logic [PR-1:0]   t_old;
    logic [4:0]      arch_reg;
    logic            precise_state_need;
    logic [XLEN-1:0] target_pc;
    logic            halt;
  } rob_entry_t;
endpackage

module retire_stage
  import retire_stage_pkg::*;
#(
  parameter int WAYS      = 3,
  parameter int ARCH_REGS = 32
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  rob_entry_t [WAYS-1:0]         i_rob_head_entry,
  output logic [WAYS-1:0]               o_retire_valid,
  output logic [WAYS-1:0]               o_free_valid,
  output logic [WAYS-1:0][PR-1:0]       o_free_pr,
  output logic                          o_bp_recover_en,
  output logic [XLEN-1:0]               o_recover_pc,
  output logic [ARCH_REGS-1:0][PR-1:0]  o_archmap,
  output logic                          o_halt,
  output logic [31:0]                   o_retired_count
);

  typedef enum logic [1:0] {S_NORMAL, S_RECOVER, S_HALTED} state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [WAYS-1:0]               w_commit;
  logic                          w_mispredict;
  logic                          w_halt_commit;
  logic [XLEN-1:0]               w_target_pc;
  logic [31:0]                   w_commit_count;
  logic [ARCH_REGS-1:0][PR-1:0]  r_archmap;
  logic                          r_bp_recover_en;
  logic [XLEN-1:0]               r_recover_pc;
  logic                          r_halt;
  logic [31:0]                   r_retired_count;

  // Walk from the head (oldest) downward; a mispredict or halt closes the window.
  always_comb begin
    logic open_q;
    logic c_q;
    w_commit      = '0;
    w_mispredict  = 1'b0;
    w_halt_commit = 1'b0;
    w_target_pc   = '0;
    open_q        = (r_state == S_NORMAL) && !i_reset;
    for (int w = WAYS - 1; w >= 0; w--) begin
      c_q         = open_q && i_rob_head_entry[w].valid && i_rob_head_entry[w].completed;
      w_commit[w] = c_q;
      if (c_q && i_rob_head_entry[w].precise_state_need) begin
        w_mispredict = 1'b1;
        w_target_pc  = i_rob_head_entry[w].target_pc;
      end
      if (c_q && i_rob_head_entry[w].halt) begin
        w_halt_commit = 1'b1;
      end
      open_q = c_q && !i_rob_head_entry[w].precise_state_need && !i_rob_head_entry[w].halt;
    end
  end

  always_comb begin
    w_commit_count = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_commit_count = w_commit_count + 32'(w_commit[w]);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_NORMAL: begin
        if (w_halt_commit) begin
          w_state_next = S_HALTED;
        end else if (w_mispredict) begin
          w_state_next = S_RECOVER;
        end
      end
      S_RECOVER: w_state_next = S_NORMAL;
      S_HALTED:  w_state_next = S_HALTED;
      default:   w_state_next = S_NORMAL;
    endcase
  end

  assign o_retire_valid = w_commit;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign o_free_valid[gi] = w_commit[gi] && (i_rob_head_entry[gi].arch_reg != 5'd0);
      assign o_free_pr[gi]    = o_free_valid[gi] ? i_rob_head_entry[gi].t_old : '0;
    end
  endgenerate

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_NORMAL;
      r_bp_recover_en <= 1'b0;
      r_recover_pc    <= '0;
      r_halt          <= 1'b0;
      r_retired_count <= '0;
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_archmap[i] <= PR'(i);
      end
    end else begin
      r_state         <= w_state_next;
      r_bp_recover_en <= (w_state_next == S_RECOVER);
      r_halt          <= r_halt | w_halt_commit;
      r_retired_count <= r_retired_count + w_commit_count;
      if (w_mispredict) begin
        r_recover_pc <= w_target_pc;
      end
      // Oldest first so the youngest writer of a shared arch_reg lands last.
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (o_free_valid[w]) begin
          r_archmap[i_rob_head_entry[w].arch_reg] <= i_rob_head_entry[w].t_new;
        end
      end
    end
  end

  assign o_bp_recover_en = r_bp_recover_en;
  assign o_recover_pc    = r_recover_pc;
  assign o_archmap       = r_archmap;
  assign o_halt          = r_halt;
  assign o_retired_count = r_retired_count;

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: expected commit vectors are queued as the
// head window is driven and compared when the commit outputs settle.
module tb_retire_stage;
  import retire_stage_pkg::*;

  localparam int WAYS      = 3;
  localparam int ARCH_REGS = 32;

  typedef struct packed {
    logic [WAYS-1:0]         rv;
    logic [WAYS-1:0]         fv;
    logic [WAYS-1:0][PR-1:0] fp;
  } exp_t;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  rob_entry_t [WAYS-1:0]        ent = '0;
  logic [WAYS-1:0]              retire_valid;
  logic [WAYS-1:0]              free_valid;
  logic [WAYS-1:0][PR-1:0]      free_pr;
  logic                         bp_recover_en;
  logic [XLEN-1:0]              recover_pc;
  logic [ARCH_REGS-1:0][PR-1:0] archmap;
  logic                         halt;
  logic [31:0]                  retired_count;

  exp_t sb[$];
  exp_t e_q;
  exp_t g_q;
  int   n_tests = 0;
  int   n_fail  = 0;

  retire_stage #(.WAYS(WAYS), .ARCH_REGS(ARCH_REGS)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_rob_head_entry (ent),
    .o_retire_valid   (retire_valid),
    .o_free_valid     (free_valid),
    .o_free_pr        (free_pr),
    .o_bp_recover_en  (bp_recover_en),
    .o_recover_pc     (recover_pc),
    .o_archmap        (archmap),
    .o_halt           (halt),
    .o_retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  function automatic rob_entry_t mk(logic c, int arch, int told, int tnew,
                                    logic psn, logic [31:0] pc, logic h);
    rob_entry_t e;
    e.valid              = 1'b1;
    e.completed          = c;
    e.arch_reg           = 5'(arch);
    e.t_old              = PR'(told);
    e.t_new              = PR'(tnew);
    e.precise_state_need = psn;
    e.target_pc          = pc;
    e.halt               = h;
    return e;
  endfunction

  task automatic drive(input rob_entry_t e2, input rob_entry_t e1, input rob_entry_t e0);
    @(posedge clk);
    #1;
    ent[2] = e2;
    ent[1] = e1;
    ent[0] = e0;
  endtask

  task automatic push_exp(input logic [2:0] rv, input logic [2:0] fv,
                          input int p2, input int p1, input int p0);
    exp_t x;
    x.rv = rv;
    x.fv = fv;
    x.fp = {PR'(p2), PR'(p1), PR'(p0)};
    sb.push_back(x);
  endtask

  function automatic int archmap_identity_errors();
    int n = 0;
    for (int i = 0; i < ARCH_REGS; i++) begin
      if (archmap[i] !== PR'(i)) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    ent[2] = mk(1, 1, 1, 32, 0, 0, 0);
    ent[1] = mk(1, 2, 2, 33, 0, 0, 0);
    ent[0] = mk(1, 3, 3, 34, 0, 0, 0);
    push_exp(3'b000, 3'b000, 0, 0, 0);
    @(negedge clk);
    g_q = {retire_valid, free_valid, free_pr};
    e_q = sb.pop_front();
    n_tests++;
    if (g_q !== e_q) begin n_fail++; $display("FAIL reset_commit_gate got=%h exp=%h", g_q, e_q); end
    n_tests++;
    if ({bp_recover_en, recover_pc, halt, retired_count} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_regs bp=%b pc=%h halt=%b cnt=%0d exp all 0", bp_recover_en, recover_pc, halt, retired_count);
    end
    n_tests++;
    if (archmap_identity_errors() != 0) begin
      n_fail++; $display("FAIL reset_archmap got %0d non-identity entries exp 0", archmap_identity_errors());
    end
    ent = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_full_commit();
    drive(mk(1, 1, 1, 32, 0, 0, 0), mk(1, 2, 2, 33, 0, 0, 0), mk(1, 3, 3, 34, 0, 0, 0));
    push_exp(3'b111, 3'b111, 1, 2, 3);
    @(negedge clk);
    g_q = {retire_valid, free_valid, free_pr};
    e_q = sb.pop_front();
    n_tests++;
    if (g_q !== e_q) begin n_fail++; $display("FAIL full_commit got=%h exp=%h", g_q, e_q); end
    drive('0, '0, '0);
    push_exp(3'b000, 3'b000, 0, 0, 0);
    @(negedge clk);
    g_q = {retire_valid, free_valid, free_pr};
    e_q = sb.pop_front();
    n_tests++;
    if (g_q !== e_q) begin n_fail++; $display("FAIL empty_head got=%h exp=%h", g_q, e_q); end
    n_tests++;
    if ({archmap[1], archmap[2], archmap[3]} !== {6'd32, 6'd33, 6'd34}) begin
      n_fail++; $display("FAIL full_archmap got=%0d,%0d,%0d exp=32,33,34", archmap[1], archmap[2], archmap[3]);
    end
    n_tests++;
    if (retired_count !== 32'd3) begin n_fail++; $display("FAIL full_count got=%0d exp=3", retired_count); end
  endtask

  task automatic test_partial();
    drive(mk(1, 4, 4, 35, 0, 0, 0), mk(0, 5, 5, 60, 0, 0, 0), mk(1, 6, 6, 61, 0, 0, 0));
    push_exp(3'b100, 3'b100, 4, 0, 0);
    @(negedge clk);
    g_q = {retire_valid, free_valid, free_pr};
    e_q = sb.pop_front();
    n_tests++;
    if (g_q !== e_q) begin n_fail++; $display("FAIL partial got=%h exp=%h", g_q, e_q); end
    drive('0, '0, '0);
    @(negedge clk);
    n_tests++;
    if ({archmap[4], archmap[6], retired_count} !== {6'd35, 6'd6, 32'd4}) begin
      n_fail++; $display("FAIL partial_state map4=%0d map6=%0d cnt=%0d exp 35,6,4", archmap[4], archmap[6], retired_count);
    end
  endtask

  task automatic test_mispredict();
    rob_entry_t a2, a1, a0;
    a2 = mk(1, 7, 7, 36, 0, 0, 0);
    a1 = mk(1, 8, 8, 37, 1, 32'd32, 0);
    a0 = mk(1, 9, 9, 38, 0, 0, 0);
    drive(a2, a1, a0);
    push_exp(3'b110, 3'b110, 7, 8, 0);
    @(negedge clk);
    g_q = {retire_valid, free_valid, free_pr};
    e_q = sb.pop_front();
    n_tests++;
    if (g_q !== e_q) begin n_fail++; $display("FAIL mispredict_commit got=%h exp=%h", g_q, e_q); end
    drive(a2, a1, a0);
    push_exp(3'b000, 3'b000, 0, 0, 0);
    @(negedge clk);
    g_q = {retire_valid, free_valid, free_pr};
    e_q = sb.pop_front();
    n_tests++;
    if (g_q !== e_q) begin n_fail++; $display("FAIL recover_blocks_commit got=%h exp=%h", g_q, e_q); end
    n_tests++;
    if ({bp_recover_en, recover_pc} !== {1'b1, 32'd32}) begin
      n_fail++; $display("FAIL recover_pulse bp=%b pc=%0d exp bp=1 pc=32", bp_recover_en, recover_pc);
    end
    n_tests++;
    if ({archmap[8], archmap[9], retired_count} !== {6'd37, 6'd9, 32'd6}) begin
      n_fail++; $display("FAIL recover_map map8=%0d map9=%0d cnt=%0d exp 37,9,6", archmap[8], archmap[9], retired_count);
    end
    drive('0, '0, '0);
    @(negedge clk);
    n_tests++;
    if ({bp_recover_en, retired_count} !== {1'b0, 32'd6}) begin
      n_fail++; $display("FAIL recover_drop bp=%b cnt=%0d exp bp=0 cnt=6", bp_recover_en, retired_count);
    end
  endtask

  task automatic test_same_arch();
    drive(mk(1, 5, 10, 40, 0, 0, 0), mk(1, 5, 11, 41, 0, 0, 0), mk(1, 0, 12, 42, 0, 0, 0));
    push_exp(3'b111, 3'b110, 10, 11, 0);
    @(negedge clk);
    g_q = {retire_valid, free_valid, free_pr};
    e_q = sb.pop_front();
    n_tests++;
    if (g_q !== e_q) begin n_fail++; $display("FAIL same_arch got=%h exp=%h", g_q, e_q); end
    drive('0, '0, '0);
    @(negedge clk);
    n_tests++;
    if ({archmap[5], archmap[0], retired_count} !== {6'd41, 6'd0, 32'd9}) begin
      n_fail++; $display("FAIL same_arch_map map5=%0d map0=%0d cnt=%0d exp 41,0,9", archmap[5], archmap[0], retired_count);
    end
  endtask

  task automatic test_back_to_back();
    drive(mk(1, 10, 13, 43, 0, 0, 0), '0, '0);
    push_exp(3'b100, 3'b100, 13, 0, 0);
    @(negedge clk);
    g_q = {retire_valid, free_valid, free_pr};
    e_q = sb.pop_front();
    n_tests++;
    if (g_q !== e_q) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", g_q, e_q); end
    drive(mk(1, 11, 14, 44, 0, 0, 0), mk(1, 12, 15, 45, 0, 0, 0), mk(1, 13, 16, 46, 0, 0, 0));
    push_exp(3'b111, 3'b111, 14, 15, 16);
    @(negedge clk);
    g_q = {retire_valid, free_valid, free_pr};
    e_q = sb.pop_front();
    n_tests++;
    if (g_q !== e_q) begin n_fail++; $display("FAIL b2b_second got=%h exp=%h", g_q, e_q); end
    drive('0, '0, '0);
    @(negedge clk);
    n_tests++;
    if ({archmap[10], archmap[11], archmap[13], retired_count} !== {6'd43, 6'd44, 6'd46, 32'd13}) begin
      n_fail++;
      $display("FAIL b2b_state map10=%0d map11=%0d map13=%0d cnt=%0d exp 43,44,46,13", archmap[10], archmap[11], archmap[13], retired_count);
    end
  endtask

  task automatic test_halt();
    drive(mk(1, 14, 17, 47, 0, 0, 1), mk(1, 15, 18, 48, 0, 0, 0), mk(1, 16, 19, 49, 0, 0, 0));
    push_exp(3'b100, 3'b100, 17, 0, 0);
    @(negedge clk);
    g_q = {retire_valid, free_valid, free_pr};
    e_q = sb.pop_front();
    n_tests++;
    if (g_q !== e_q) begin n_fail++; $display("FAIL halt_commit got=%h exp=%h", g_q, e_q); end
    for (int k = 0; k < 3; k++) begin
      drive(mk(1, 20, 20, 50, 0, 0, 0), mk(1, 21, 21, 51, 0, 0, 0), mk(1, 22, 22, 52, 0, 0, 0));
      push_exp(3'b000, 3'b000, 0, 0, 0);
      @(negedge clk);
      g_q = {retire_valid, free_valid, free_pr};
      e_q = sb.pop_front();
      n_tests++;
      if (g_q !== e_q) begin n_fail++; $display("FAIL halted_commit[%0d] got=%h exp=%h", k, g_q, e_q); end
      n_tests++;
      if ({halt, retired_count, archmap[14], archmap[20]} !== {1'b1, 32'd14, 6'd47, 6'd20}) begin
        n_fail++;
        $display("FAIL halted_state[%0d] halt=%b cnt=%0d map14=%0d map20=%0d exp 1,14,47,20", k, halt, retired_count, archmap[14], archmap[20]);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({halt, retired_count} !== 33'd0 || archmap_identity_errors() != 0) begin
      n_fail++; $display("FAIL halt_reset halt=%b cnt=%0d exp 0,0 identity", halt, retired_count);
    end
    ent = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_in_recover();
    drive(mk(1, 1, 20, 50, 1, 32'h1234, 0), '0, '0);
    push_exp(3'b100, 3'b100, 20, 0, 0);
    @(negedge clk);
    g_q = {retire_valid, free_valid, free_pr};
    e_q = sb.pop_front();
    n_tests++;
    if (g_q !== e_q) begin n_fail++; $display("FAIL rr_commit got=%h exp=%h", g_q, e_q); end
    drive('0, '0, '0);
    @(negedge clk);
    n_tests++;
    if ({bp_recover_en, recover_pc, archmap[1]} !== {1'b1, 32'h1234, 6'd50}) begin
      n_fail++; $display("FAIL rr_recover bp=%b pc=%h map1=%0d exp 1,1234,50", bp_recover_en, recover_pc, archmap[1]);
    end
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bp_recover_en, recover_pc, halt, retired_count} !== 66'd0 || archmap_identity_errors() != 0) begin
      n_fail++;
      $display("FAIL rr_reset bp=%b pc=%h halt=%b cnt=%0d idErr=%0d exp all 0", bp_recover_en, recover_pc, halt, retired_count, archmap_identity_errors());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_commit();
    test_partial();
    test_mispredict();
    test_same_arch();
    test_back_to_back();
    test_halt();
    test_reset_in_recover();
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain left=%0d exp 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
